// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and frame-length helper.
// Used by the transmitter and intended for the matching receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_w,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: emits a one-cycle tick after every BAUD_DIV enabled cycles.
// The synchronous clear realigns the count to the start of a bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(BAUD_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: valid/ready word intake, LSB-first serialisation with optional parity
// and one or two stop bits, registered line output and a frame-completion pulse.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = 5208,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rs232_tx,
  output logic              tx_busy,
  output logic              tx_done
);

  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
    $error("uart_tx_frame: DATA_W must be within 5..9");
  end
  if (BAUD_DIV < 4) begin : g_bad_baud
    $error("uart_tx_frame: BAUD_DIV must be at least 4");
  end

  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_W - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              par_q, par_d;
  logic              line_q, line_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .sclk   (sclk),
    .s_rst_n(s_rst_n),
    .en     (state_q != ST_IDLE),
    .clr    (state_q == ST_IDLE),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d = ST_START;
          shift_d = tx_data;
          bit_d   = '0;
          par_d   = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == DataLast) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_q == StopLast) begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the next state so it changes on the same edge as the FSM.
    case (state_d)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_d[0];
      ST_PARITY: line_d = par_d;
      default:   line_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready = (state_q == ST_IDLE);
  assign rs232_tx = line_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: several parameter sets run side by side, each with
// its own stimulus, handshake observer and serial-line monitor against a frame model.
module tb_uart_tx_frame;

  localparam int NCfg = 6;

  typedef struct {
    logic [8:0] d;
    int         start;
  } item_t;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_fin  = 0;

  // Field 0 baud divisor, 1 data width, 2 parity mode, 3 stop bits, 4 directed word.
  function automatic int cfg(input int g, input int f);
    int t[5];
    case (g)
      0:       t = '{16, 8, 0, 1, 'hA5};
      1:       t = '{16, 8, 2, 1, 'h07};
      2:       t = '{16, 8, 1, 1, 'h07};
      3:       t = '{16, 7, 0, 2, 'h55};
      4:       t = '{5, 9, 2, 2, 'h1A3};
      default: t = '{4, 5, 1, 1, 'h13};
    endcase
    return t[f];
  endfunction

  task automatic chk(input bit ok, input string name, input int g, input int act,
                     input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h", g, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCfg; g++) begin : g_cfg
    localparam int BD = cfg(g, 0);
    localparam int DW = cfg(g, 1);
    localparam int PA = cfg(g, 2);
    localparam int SB = cfg(g, 3);
    localparam int W0 = cfg(g, 4);
    localparam int NB = 1 + DW + ((PA != 0) ? 1 : 0) + SB;
    localparam int FL = NB * BD;

    logic          rst_n, valid, ready, line, busy, done;
    logic [DW-1:0] data;
    item_t         exp_q[$];
    int            n_acc = 0;
    int            n_frm = 0;
    int            n_drop = 0;

    uart_tx_frame #(
      .BAUD_DIV (BD),
      .DATA_W   (DW),
      .PARITY   (PA),
      .STOP_BITS(SB)
    ) u_dut (
      .sclk    (sclk),
      .s_rst_n (rst_n),
      .tx_valid(valid),
      .tx_data (data),
      .tx_ready(ready),
      .rs232_tx(line),
      .tx_busy (busy),
      .tx_done (done)
    );

    // Expected line level at cycle i after the start edge, from the frame layout.
    function automatic logic exp_level(input logic [8:0] d, input int i);
      int b = i / BD;
      int ones = $countones(d);
      if (b == 0) return 1'b0;
      if (b <= DW) return d[b-1];
      if (PA != 0 && b == DW + 1) return (PA == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      return 1'b1;
    endfunction

    // Handshake observer: every accepted word becomes an expected frame.
    initial begin
      item_t it;
      forever begin
        @(negedge sclk);
        #1;
        if (rst_n && valid && ready) begin
          it.d = '0;
          it.d[DW-1:0] = data;
          it.start = cyc + 1;
          exp_q.push_back(it);
          n_acc++;
        end
      end
    end

    // Line monitor: decodes each frame cycle by cycle against the model.
    initial begin
      item_t cur;
      bit    in_f;
      int    i, bad_line, bad_ctl, first_bad;
      in_f = 1'b0;
      i = 0;
      bad_line = 0;
      bad_ctl = 0;
      first_bad = -1;
      cur.d = '0;
      cur.start = 0;
      forever begin
        @(negedge sclk);
        if (!rst_n) begin
          in_f = 1'b0;
          continue;
        end
        if (!in_f) begin
          if (line == 1'b0) begin
            if (exp_q.size() == 0) begin
              chk(1'b0, "unexpected_frame", g, cyc, 0);
              cur.d = '0;
              cur.start = cyc;
            end else begin
              cur = exp_q.pop_front();
              chk(cyc == cur.start, "start_latency", g, cyc, cur.start);
            end
            in_f = 1'b1;
            i = 0;
            bad_line = 0;
            bad_ctl = 0;
            first_bad = -1;
          end else begin
            chk({done, busy, ready} === 3'b001, "idle_flags", g, {done, busy, ready}, 1);
          end
        end
        if (in_f) begin
          if (i < FL) begin
            if (line !== exp_level(cur.d, i)) begin
              if (bad_line == 0) first_bad = i;
              bad_line++;
            end
            if ({done, busy, ready} !== 3'b010) bad_ctl++;
            i++;
          end else begin
            chk(bad_line == 0, "frame_bits_bad_cycles", g, bad_line, 0);
            if (bad_line != 0)
              $display("  cfg%0d word 0x%0h first bad cycle %0d", g, cur.d, first_bad);
            chk(bad_ctl == 0, "frame_ctrl_bad_cycles", g, bad_ctl, 0);
            chk({done, busy, ready, line} === 4'b1011, "frame_end_flags", g,
                {done, busy, ready, line}, 4'b1011);
            in_f = 1'b0;
            n_frm++;
          end
        end
      end
    end

    task automatic send(input logic [DW-1:0] w, output int acc);
      int t;
      @(negedge sclk);
      valid = 1'b1;
      data = w;
      t = 0;
      while (!ready && t < 4 * FL) begin
        @(negedge sclk);
        t++;
      end
      chk(ready == 1'b1, "accept_wait", g, t, 0);
      acc = cyc + 1;
      @(negedge sclk);
      valid = 1'b0;
    endtask

    task automatic wait_idle();
      int t = 0;
      while ((n_frm + n_drop) != n_acc && t < 4 * FL) begin
        @(negedge sclk);
        t++;
      end
      chk((n_frm + n_drop) == n_acc, "frames_complete", g, n_frm + n_drop, n_acc);
      repeat (2) @(negedge sclk);
    endtask

    initial begin
      logic [DW-1:0] w;
      int a1, a2, t, f0, target;
      rst_n = 1'b0;
      valid = 1'b0;
      data = '0;
      repeat (3) @(negedge sclk);
      chk({line, ready, busy, done} === 4'b1100, "reset_values", g,
          {line, ready, busy, done}, 4'b1100);
      #2 rst_n = 1'b1;

      w = W0[DW-1:0];
      send(w, a1);
      wait_idle();

      // Valid pulsed while busy must not start a second frame.
      f0 = n_frm;
      send(DW'($urandom), a1);
      repeat (2 * BD) @(negedge sclk);
      valid = 1'b1;
      data = DW'($urandom);
      repeat (2) @(negedge sclk);
      valid = 1'b0;
      wait_idle();
      chk(n_frm == f0 + 1, "busy_pulse_one_frame", g, n_frm - f0, 1);

      // Back-to-back with valid held; data changes mid-frame must not leak in.
      @(negedge sclk);
      valid = 1'b1;
      data = '0;
      data[0] = 1'b1;
      t = 0;
      while (!ready && t < FL) begin
        @(negedge sclk);
        t++;
      end
      a1 = cyc + 1;
      repeat (2 * BD) @(negedge sclk);
      data = '0;
      data[DW-1] = 1'b1;
      t = 0;
      @(negedge sclk);
      while (!ready && t < 2 * FL) begin
        @(negedge sclk);
        t++;
      end
      a2 = cyc + 1;
      chk(a2 == a1 + FL + 1, "b2b_gap", g, a2 - a1, FL + 1);
      @(negedge sclk);
      valid = 1'b0;
      wait_idle();

      for (int n = 0; n < 6; n++) begin
        repeat ($urandom_range(0, 4)) @(negedge sclk);
        send(DW'($urandom), a1);
        if ($urandom_range(0, 1) == 1) begin
          repeat (BD) @(negedge sclk);
          valid = 1'b1;
          data = DW'($urandom);
          @(negedge sclk);
          valid = 1'b0;
        end
      end
      wait_idle();

      // Asynchronous reset in the middle of data bit 3.
      f0 = n_frm;
      send(DW'($urandom), a1);
      target = a1 + 4 * BD + BD / 2;
      while (cyc < target) @(negedge sclk);
      #2 rst_n = 1'b0;
      #1;
      chk({line, busy, done, ready} === 4'b1001, "async_reset_mid_frame", g,
          {line, busy, done, ready}, 4'b1001);
      n_drop++;
      repeat (2) @(negedge sclk);
      #2 rst_n = 1'b1;
      send(DW'($urandom), a1);
      wait_idle();
      chk(n_frm == f0 + 1, "post_reset_frames", g, n_frm - f0, 1);

      repeat (3) @(negedge sclk);
      chk(exp_q.size() == 0, "queue_drained", g, exp_q.size(), 0);
      n_fin++;
    end
  end

  initial begin
    int t;
    t = 0;
    while (n_fin < NCfg && t < 60000) begin
      @(negedge sclk);
      t++;
    end
    if (n_fin < NCfg) chk(1'b0, "watchdog", -1, n_fin, NCfg);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
